// File: rtl/draw_pkg.sv
// Shared types and constants for the drawing-mode controller.
package draw_pkg;

    localparam int DEF_X_W = 8;
    localparam int DEF_Y_W = 7;
    localparam int DEF_C_W = 3;

    localparam logic [1:0] MODE_OFF     = 2'b00;
    localparam logic [1:0] MODE_FREE    = 2'b01;
    localparam logic [1:0] MODE_FILL    = 2'b10;
    localparam logic [1:0] MODE_OUTLINE = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_P1,
        WAIT_REL,
        LOAD_P2,
        SCAN,
        FREE,
        DONE
    } state_t;

endpackage

// File: rtl/draw_controller_rect_scanner.sv
// Row-major pixel walker over a normalised rectangle; one position per step.
// Registered x/y; on_border and last are combinational from the counters.
module rect_scanner #(
    parameter int X_W = 8,
    parameter int Y_W = 7
) (
    input  logic           Clock,
    input  logic           reset_N,
    input  logic           load,
    input  logic           step,
    input  logic [X_W-1:0] xmin,
    input  logic [X_W-1:0] xmax,
    input  logic [Y_W-1:0] ymin,
    input  logic [Y_W-1:0] ymax,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           on_border,
    output logic           last
);

    always_ff @(posedge Clock) begin
        if (!reset_N) begin
            x <= '0;
            y <= '0;
        end else if (load) begin
            x <= xmin;
            y <= ymin;
        end else if (step) begin
            if (x == xmax) begin
                x <= xmin;
                y <= y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    assign on_border = (x == xmin) || (x == xmax) || (y == ymin) || (y == ymax);
    assign last      = (x == xmax) && (y == ymax);

endmodule

// File: rtl/draw_controller.sv
// Captures two corners from the user inputs and streams pixel writes for a
// filled/outline rectangle, or passes coordinates through in free-form mode.
module draw_controller
    import draw_pkg::*;
#(
    parameter int X_W = DEF_X_W,
    parameter int Y_W = DEF_Y_W,
    parameter int C_W = DEF_C_W
) (
    input  logic           Clock,
    input  logic           reset_N,
    input  logic [1:0]     mode,
    input  logic           start,
    input  logic [X_W-1:0] x_in,
    input  logic [Y_W-1:0] y_in,
    input  logic [C_W-1:0] c_in,
    output logic           plot,
    output logic [X_W-1:0] x_out,
    output logic [Y_W-1:0] y_out,
    output logic [C_W-1:0] c_out,
    output logic           busy,
    output logic           done
);

    state_t         state, state_d;
    logic           start_q;
    logic [1:0]     mode_q;
    logic [X_W-1:0] x1_q, xmin_q, xmax_q;
    logic [Y_W-1:0] y1_q, ymin_q, ymax_q;
    logic [C_W-1:0] c_q;

    logic           rise, fall;
    logic [X_W-1:0] nxmin, nxmax, sc_xmin, sc_x;
    logic [Y_W-1:0] nymin, nymax, sc_ymin, sc_y;
    logic           sc_border, sc_last;

    assign rise = start & ~start_q;
    assign fall = ~start & start_q;

    // P2 is live on the inputs during LOAD_P2, so normalise against it directly
    assign nxmin = (x1_q <= x_in) ? x1_q : x_in;
    assign nxmax = (x1_q <= x_in) ? x_in : x1_q;
    assign nymin = (y1_q <= y_in) ? y1_q : y_in;
    assign nymax = (y1_q <= y_in) ? y_in : y1_q;

    assign sc_xmin = (state == LOAD_P2) ? nxmin : xmin_q;
    assign sc_ymin = (state == LOAD_P2) ? nymin : ymin_q;

    rect_scanner #(.X_W(X_W), .Y_W(Y_W)) u_scan (
        .Clock     (Clock),
        .reset_N   (reset_N),
        .load      (state == LOAD_P2),
        .step      (state == SCAN),
        .xmin      (sc_xmin),
        .xmax      (xmax_q),
        .ymin      (sc_ymin),
        .ymax      (ymax_q),
        .x         (sc_x),
        .y         (sc_y),
        .on_border (sc_border),
        .last      (sc_last)
    );

    always_ff @(posedge Clock) begin
        if (!reset_N) state <= IDLE;
        else          state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (rise && mode[1])                  state_d = LOAD_P1;
                else if (mode == MODE_FREE && start)  state_d = FREE;
            end
            LOAD_P1:  state_d = WAIT_REL;
            WAIT_REL: if (fall) state_d = LOAD_P2;
            LOAD_P2:  state_d = SCAN;
            SCAN:     if (sc_last) state_d = DONE;
            FREE:     if (!start || mode != MODE_FREE) state_d = IDLE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        // Switching off aborts from anywhere, ahead of every other transition
        if (mode == MODE_OFF) state_d = IDLE;
    end

    always_ff @(posedge Clock) begin
        if (!reset_N) begin
            start_q <= 1'b0;
            mode_q  <= MODE_OFF;
            x1_q    <= '0;
            y1_q    <= '0;
            c_q     <= '0;
            xmin_q  <= '0;
            xmax_q  <= '0;
            ymin_q  <= '0;
            ymax_q  <= '0;
        end else begin
            start_q <= start;
            if (state == IDLE && state_d == LOAD_P1) mode_q <= mode;
            if (state == LOAD_P1) begin
                x1_q <= x_in;
                y1_q <= y_in;
                c_q  <= c_in;
            end
            if (state == LOAD_P2) begin
                xmin_q <= nxmin;
                xmax_q <= nxmax;
                ymin_q <= nymin;
                ymax_q <= nymax;
            end
        end
    end

    always_comb begin
        plot  = 1'b0;
        x_out = '0;
        y_out = '0;
        c_out = '0;
        done  = 1'b0;
        case (state)
            SCAN: begin
                plot  = (mode_q == MODE_FILL) || sc_border;
                x_out = sc_x;
                y_out = sc_y;
                c_out = c_q;
            end
            FREE: begin
                plot  = 1'b1;
                x_out = x_in;
                y_out = y_in;
                c_out = c_in;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_draw_controller.sv
// Bench for draw_controller: table-driven and random rectangles against a
// row-major pixel model, plus free-form, abort and reset sequences.
module tb_draw_controller;
    import draw_pkg::*;

    logic       Clock = 1'b0;
    logic       reset_N = 1'b0;
    logic [1:0] mode = MODE_OFF;
    logic       start = 1'b0;
    logic [7:0] x_in = '0;
    logic [6:0] y_in = '0;
    logic [2:0] c_in = '0;
    logic       plot, busy, done;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] c_out;

    int total = 0;
    int bad = 0;

    draw_controller #(.X_W(8), .Y_W(7), .C_W(3)) dut (
        .Clock   (Clock),
        .reset_N (reset_N),
        .mode    (mode),
        .start   (start),
        .x_in    (x_in),
        .y_in    (y_in),
        .c_in    (c_in),
        .plot    (plot),
        .x_out   (x_out),
        .y_out   (y_out),
        .c_out   (c_out),
        .busy    (busy),
        .done    (done)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [1:0] m;
        int x1, y1, x2, y2, c;
        int exp_plots;
    } vec_t;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, " busy"}, int'(busy), 0);
        chk({name, " plot"}, int'(plot), 0);
        chk({name, " done"}, int'(done), 0);
    endtask

    // Drives a full two-corner capture; returns with the first SCAN pixel live.
    task automatic enter_rect(input logic [1:0] m, input int x1, input int y1,
                              input int x2, input int y2, input int c, input string tag);
        mode  = m;
        x_in  = 8'(x1);
        y_in  = 7'(y1);
        c_in  = 3'(c);
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        chk({tag, " p1 busy"}, int'(busy), 1);
        chk({tag, " p1 plot"}, int'(plot), 0);
        tick();
        x_in = 8'(x2);
        y_in = 7'(y2);
        c_in = 3'(c + 1);
        tick();
        chk({tag, " wait plot"}, int'(plot), 0);
        start = 1'b0;
        tick();
        tick();
        x_in = 8'($urandom);
        y_in = 7'($urandom);
        c_in = 3'($urandom);
    endtask

    task automatic run_rect(input logic [1:0] m, input int x1, input int y1,
                            input int x2, input int y2, input int c,
                            input int exp_plots, input string tag);
        int  xlo, xhi, ylo, yhi, nplot;
        bit  ref_plot;
        xlo = (x1 < x2) ? x1 : x2;
        xhi = (x1 < x2) ? x2 : x1;
        ylo = (y1 < y2) ? y1 : y2;
        yhi = (y1 < y2) ? y2 : y1;
        nplot = 0;
        enter_rect(m, x1, y1, x2, y2, c, tag);
        // mode changes after latching must not affect the rectangle
        mode = {1'b1, ~m[0]};
        for (int yy = ylo; yy <= yhi; yy++) begin
            for (int xx = xlo; xx <= xhi; xx++) begin
                ref_plot = (m == MODE_FILL) || xx == xlo || xx == xhi || yy == ylo || yy == yhi;
                chk({tag, " x"}, int'(x_out), xx);
                chk({tag, " y"}, int'(y_out), yy);
                chk({tag, " plot"}, int'(plot), int'(ref_plot));
                chk({tag, " done_early"}, int'(done), 0);
                if (ref_plot) chk({tag, " c"}, int'(c_out), c);
                nplot += int'(plot);
                tick();
                x_in = 8'($urandom);
                c_in = 3'($urandom);
            end
        end
        chk({tag, " done"}, int'(done), 1);
        chk({tag, " done plot"}, int'(plot), 0);
        chk({tag, " plots"}, nplot, exp_plots);
        tick();
        chk_idle({tag, " after"});
    endtask

    initial begin
        vec_t tbl[5];
        tbl[0] = '{MODE_FILL,    2,   3,   4,   5, 5, 9};
        tbl[1] = '{MODE_FILL,    4,   5,   2,   3, 5, 9};
        tbl[2] = '{MODE_OUTLINE, 0,   0,   2,   2, 3, 8};
        tbl[3] = '{MODE_FILL,    7,   7,   7,   7, 6, 1};
        tbl[4] = '{MODE_OUTLINE, 255, 127, 250, 120, 1, 24};

        // Reset state
        tick();
        tick();
        chk_idle("reset");
        chk("reset x", int'(x_out), 0);
        chk("reset y", int'(y_out), 0);
        chk("reset c", int'(c_out), 0);
        reset_N = 1'b1;
        tick();

        for (int i = 0; i < 5; i++)
            run_rect(tbl[i].m, tbl[i].x1, tbl[i].y1, tbl[i].x2, tbl[i].y2,
                     tbl[i].c, tbl[i].exp_plots, $sformatf("tbl%0d", i));

        for (int r = 0; r < 12; r++) begin
            int xa, xb, ya, yb, w, h, ep, t;
            logic [1:0] m;
            xa = $urandom_range(0, 250);
            xb = xa + $urandom_range(0, 5);
            ya = $urandom_range(0, 122);
            yb = ya + $urandom_range(0, 5);
            if ($urandom_range(0, 1) == 1) begin t = xa; xa = xb; xb = t; end
            if ($urandom_range(0, 1) == 1) begin t = ya; ya = yb; yb = t; end
            m = ($urandom_range(0, 1) == 1) ? MODE_OUTLINE : MODE_FILL;
            w = ((xa > xb) ? xa - xb : xb - xa) + 1;
            h = ((ya > yb) ? ya - yb : yb - ya) + 1;
            ep = w * h;
            if (m == MODE_OUTLINE) ep -= ((w > 2) ? w - 2 : 0) * ((h > 2) ? h - 2 : 0);
            run_rect(m, xa, ya, xb, yb, $urandom_range(0, 7), ep, $sformatf("rnd%0d", r));
        end

        // Free-form: outputs follow the inputs in the same cycle
        mode  = MODE_FREE;
        start = 1'b1;
        x_in  = 8'd10;
        y_in  = 7'd20;
        tick();
        for (int i = 0; i < 4; i++) begin
            x_in = 8'(10 + i);
            c_in = 3'(i);
            #1;
            chk("free plot", int'(plot), 1);
            chk("free x", int'(x_out), 10 + i);
            chk("free y", int'(y_out), 20);
            chk("free c", int'(c_out), i);
            chk("free done", int'(done), 0);
            tick();
        end
        start = 1'b0;
        tick();
        chk_idle("free exit");
        start = 1'b1;
        tick();
        chk("free2 busy", int'(busy), 1);
        mode = MODE_FILL;
        tick();
        chk_idle("free mode exit");
        tick();
        chk_idle("free no rect");
        start = 1'b0;
        tick();

        // Abort during WAIT_REL
        mode  = MODE_FILL;
        x_in  = 8'd1;
        y_in  = 7'd1;
        tick();
        start = 1'b1;
        tick();
        tick();
        tick();
        chk("abort wait busy", int'(busy), 1);
        mode = MODE_OFF;
        tick();
        chk_idle("abort");
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle("abort quiet");
        end

        // Reset during the third SCAN pixel
        enter_rect(MODE_FILL, 2, 3, 4, 5, 5, "rst");
        tick();
        tick();
        chk("rst px3 x", int'(x_out), 4);
        chk("rst px3 y", int'(y_out), 3);
        reset_N = 1'b0;
        tick();
        chk_idle("rst");
        chk("rst x", int'(x_out), 0);
        chk("rst y", int'(y_out), 0);
        chk("rst c", int'(c_out), 0);
        reset_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle("rst quiet");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
